contador_bcd_2dig: RTL
======================

Name: contador_bcd_2dig

Overview:
- Two-digit (00–99) BCD up/down counter with a programmable tick prescaler and synchronous parallel load.
- Sits directly upstream of the BCD-to-segment converter. It drives that converter's four-bit digit input (A = MSB … D = LSB) time-multiplexed between units and tens, plus a one-hot digit-select for the display commons.
- Also exports both digits in parallel and a terminal-count pulse for cascading.

Parameters:
- CLK_DIV, 50000000: iClk cycles per count tick (≥2).
- SCAN_DIV, 50000: iClk cycles per display-scan step (≥2).

Ports:
- iClk  input  1  system clock, all state on rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iEn  input  1  count enable; gates the tick prescaler.
- iUp  input  1  direction: 1 = up, 0 = down; sampled on the tick cycle.
- iLoad  input  1  synchronous load strobe.
- iLoadVal  input  8  load value: [7:4] tens, [3:0] units, BCD.
- oUnits  output  4  units digit, registered.
- oTens  output  4  tens digit, registered.
- oA  output  1  muxed digit bit 3 (MSB) to converter.
- oB  output  1  muxed digit bit 2.
- oC  output  1  muxed digit bit 1.
- oD  output  1  muxed digit bit 0 (LSB).
- oDigSel  output  2  one-hot: 2'b01 = units shown, 2'b10 = tens shown.
- oTc  output  1  one-cycle terminal-count pulse.

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-low on iRst_n.
- Reset values (iRst_n low, asynchronous):
  - oUnits = 0, oTens = 0, oTc = 0, oDigSel = 2'b01, {oA,oB,oC,oD} = 4'b0000.
  - Both prescalers = 0.
  - Release takes effect on the first rising edge with iRst_n high.
  - Reset mid-count or mid-load discards everything; no partial state survives.
- Tick prescaler:
  - Counts 0..CLK_DIV-1 while iEn = 1, holds while iEn = 0.
  - Tick is internal, asserted for the cycle in which the count equals CLK_DIV-1; the count wraps to 0 on the next edge.
- Load:
  - iLoad has priority over tick.
  - If iLoadVal[7:4] ≤ 9 and iLoadVal[3:0] ≤ 9: digits take the value on the next edge and the tick prescaler clears to 0.
  - Otherwise (any nibble A–F): load is ignored entirely, digits and prescaler unchanged.
  - Load never asserts oTc.
- Count on tick, with no valid load:
  - Up: units+1. Units 9→0 carries tens+1. 99→00 and oTc = 1 for exactly the next cycle.
  - Down: units-1. Units 0→9 borrows tens-1. 00→99 and oTc = 1 for exactly the next cycle.
  - Digits are never outside 0–9.
  - Latency: digit change visible one edge after the tick cycle.
- Scan:
  - Scan prescaler free-runs 0..SCAN_DIV-1, independent of iEn and iLoad.
  - At wrap, oDigSel toggles between 01 and 10.
  - {oA,oB,oC,oD} = oUnits when oDigSel = 01, oTens when oDigSel = 10.
  - The mux is combinational from registers, so it tracks digit updates in the same cycle they appear.
- Simultaneous events:
  - Load + tick: load wins; the tick is consumed.
  - iEn falling on the tick cycle: that tick still counts.
  - Direction change takes effect at the next tick.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - Up at 99 stays 99; down at 00 stays 00.
  - oTc pulses one cycle only on the tick that first reaches the limit (98→99 up, 01→00 down).
  - Further ticks at the limit produce no pulse.
  - Load behaviour is unchanged.
- Undefined: wrap behaviour as above; the 98→99 and 01→00 transitions do not pulse oTc.

Test Plan:
All tests use CLK_DIV = 4, SCAN_DIV = 3.
- Reset mid-count: count up to 37, assert iRst_n = 0 off-edge → outputs go 00 / oDigSel = 01 / oTc = 0 immediately, without waiting for a clock edge.
- Up carry: iEn = 1, iUp = 1, load 0x08 → after 2 ticks (8 cycles) digits read 10; 00→99 count sequence has no invalid nibble.
- Wrap and oTc: load 0x99, iUp = 1 → next tick gives 00 with oTc high one cycle. Then iUp = 0 → next tick gives 99 with oTc high one cycle. With BCD_SATURATE_EN: the tick leaves 99 held, no pulse.
- Invalid load: load 0x3A, then 0xA3 → digits unchanged, prescaler not cleared. Load 0x42 on the same cycle as a tick → 42, no increment.
- iEn hold: deassert iEn at prescaler = 2 for 10 cycles → digits frozen. Re-enable → next tick after 1 more cycle.
- Scan: with digits 57, oDigSel alternates every 3 cycles. {oA..oD} = 0111 when oDigSel = 01, 0101 when oDigSel = 10. A load during scan updates the mux in the same cycle as oUnits/oTens.

Source files
------------

// File: rtl/contador_bcd_2dig.sv
// Two-digit BCD up/down counter with tick prescaler, load and scan mux.
// Optional: define BCD_SATURATE_EN to saturate at 00/99 instead of wrapping.
module contador_bcd_2dig #(
  parameter int CLK_DIV  = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEn,
  input  logic       iUp,
  input  logic       iLoad,
  input  logic [7:0] iLoadVal,
  output logic [3:0] oUnits,
  output logic [3:0] oTens,
  output logic       oA,
  output logic       oB,
  output logic       oC,
  output logic       oD,
  output logic [1:0] oDigSel,
  output logic       oTc
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_scan;
  logic [3:0]    r_units;
  logic [3:0]    r_tens;
  logic          r_tc;
  logic [1:0]    r_sel;

  logic          w_tick;
  logic          w_load_ok;
  logic          w_max;
  logic          w_min;
  logic [3:0]    w_units_nx;
  logic [3:0]    w_tens_nx;
  logic          w_tc_nx;

  assign w_tick    = (r_pre == PRE_LAST);
  assign w_load_ok = iLoad
                   && (iLoadVal[7:4] <= 4'd9)
                   && (iLoadVal[3:0] <= 4'd9);
  assign w_max     = (r_tens == 4'd9) && (r_units == 4'd9);
  assign w_min     = (r_tens == 4'd0) && (r_units == 4'd0);

  // Next digit pair and terminal-count flag for one count step
  always_comb begin
    w_units_nx = r_units;
    w_tens_nx  = r_tens;
    w_tc_nx    = 1'b0;
    if (iUp) begin
      if (w_max) begin
`ifndef BCD_SATURATE_EN
        w_units_nx = 4'd0;
        w_tens_nx  = 4'd0;
        w_tc_nx    = 1'b1;
`endif
      end else if (r_units == 4'd9) begin
        w_units_nx = 4'd0;
        w_tens_nx  = r_tens + 4'd1;
      end else begin
        w_units_nx = r_units + 4'd1;
`ifdef BCD_SATURATE_EN
        w_tc_nx    = (r_tens == 4'd9) && (r_units == 4'd8);
`endif
      end
    end else begin
      if (w_min) begin
`ifndef BCD_SATURATE_EN
        w_units_nx = 4'd9;
        w_tens_nx  = 4'd9;
        w_tc_nx    = 1'b1;
`endif
      end else if (r_units == 4'd0) begin
        w_units_nx = 4'd9;
        w_tens_nx  = r_tens - 4'd1;
      end else begin
        w_units_nx = r_units - 4'd1;
`ifdef BCD_SATURATE_EN
        w_tc_nx    = (r_tens == 4'd0) && (r_units == 4'd1);
`endif
      end
    end
  end

  // Digit registers: a valid load beats the tick
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_units <= 4'd0;
      r_tens  <= 4'd0;
      r_tc    <= 1'b0;
    end else if (w_load_ok) begin
      r_units <= iLoadVal[3:0];
      r_tens  <= iLoadVal[7:4];
      r_tc    <= 1'b0;
    end else if (w_tick) begin
      r_units <= w_units_nx;
      r_tens  <= w_tens_nx;
      r_tc    <= w_tc_nx;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  // Tick prescaler; the tick cycle always wraps so a held count never re-ticks
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_pre <= '0;
    end else if (w_load_ok || w_tick) begin
      r_pre <= '0;
    end else if (iEn) begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Free-running scan prescaler toggling the digit select at wrap
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_scan <= '0;
      r_sel  <= 2'b01;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_sel  <= {r_sel[0], r_sel[1]};
    end else begin
      r_scan <= r_scan + SW'(1);
    end
  end

  assign oUnits  = r_units;
  assign oTens   = r_tens;
  assign oTc     = r_tc;
  assign oDigSel = r_sel;
  assign {oA, oB, oC, oD} = r_sel[1] ? r_tens : r_units;

endmodule
